// File: rtl/wb_initiator_if.sv
// Request/response and Wishbone signal bundle for wb_initiator.
// The master modport is the initiator's view; slave is the requester/responder side.
`timescale 1ns/1ps
interface wb_initiator_if;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [31:0] io_req_addr;
  logic [31:0] io_req_wdata;
  logic [3:0]  io_req_sel;
  logic        io_req_we;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [31:0] io_resp_rdata;
  logic        io_resp_err;
  logic [31:0] io_wb_addr;
  logic [31:0] io_wb_wdata;
  logic [3:0]  io_wb_sel;
  logic        io_wb_we;
  logic        io_wb_cyc;
  logic        io_wb_stb;
  logic [31:0] io_wb_rdata;
  logic        io_wb_ack;

  modport master (
    input  io_req_valid, io_req_addr, io_req_wdata, io_req_sel, io_req_we,
    input  io_resp_ready, io_wb_rdata, io_wb_ack,
    output io_req_ready, io_resp_valid, io_resp_rdata, io_resp_err,
    output io_wb_addr, io_wb_wdata, io_wb_sel, io_wb_we, io_wb_cyc, io_wb_stb
  );

  modport slave (
    output io_req_valid, io_req_addr, io_req_wdata, io_req_sel, io_req_we,
    output io_resp_ready, io_wb_rdata, io_wb_ack,
    input  io_req_ready, io_resp_valid, io_resp_rdata, io_resp_err,
    input  io_wb_addr, io_wb_wdata, io_wb_sel, io_wb_we, io_wb_cyc, io_wb_stb
  );
endinterface

// File: rtl/wb_initiator.sv
// Single-access Wishbone classic initiator: one valid/ready request -> one bus cycle -> one response.
// Optional ack timeout enabled by defining WB_TIMEOUT_EN.
`timescale 1ns/1ps
module wb_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clock,
  input  logic           reset,
  wb_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  // Counter is 16 bits, so the limit must fit.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_initiator: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
`ifdef WB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.io_req_valid) begin
          addr_d      = bus.io_req_addr;
          wdata_d     = bus.io_req_wdata;
          sel_d       = bus.io_req_sel;
          we_d        = bus.io_req_we;
          cyc_d       = 1'b1;
          req_ready_d = 1'b0;
          state_d     = BUS;
`ifdef WB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUS: begin
        // ack takes priority over a coincident timeout expiry
        if (bus.io_wb_ack) begin
          cyc_d        = 1'b0;
          resp_rdata_d = we_q ? 32'h0 : bus.io_wb_rdata;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          cyc_d        = 1'b0;
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        if (bus.io_resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
`ifdef WB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.io_req_ready  = req_ready_q;
  assign bus.io_resp_valid = resp_valid_q;
  assign bus.io_resp_rdata = resp_rdata_q;
  assign bus.io_resp_err   = resp_err_q;
  assign bus.io_wb_addr    = addr_q;
  assign bus.io_wb_wdata   = wdata_q;
  assign bus.io_wb_sel     = sel_q;
  assign bus.io_wb_we      = we_q;
  assign bus.io_wb_cyc     = cyc_q;
  assign bus.io_wb_stb     = cyc_q;

endmodule
